cbc_stream_decrypt_ctrl: RTL and testbench

//  Sequences a multi-byte CBC decryption message through the combinational blockDecryptorCBC datapath (8b c, 4b k, 4b iv -> 8b p).

---
 rtl/cbc_stream_decrypt_ctrl.sv | 132 +++++++++++++
 tb/tb_cbc_stream_decrypt_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cbc_stream_decrypt_ctrl.sv
// Byte-serial CBC decrypt sequencer around an external combinational block decryptor.
// Accept -> out_valid after DEC_WAIT+1 cycles; out_ready low parks the byte in EMIT and blocks new input.
module cbc_stream_decrypt_ctrl #(
   parameter int LEN_W    = 8,
   parameter int DEC_WAIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       key,
   input  logic [3:0]       iv,
   input  logic [LEN_W-1:0] len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   output logic [7:0]       dec_c,
   output logic [3:0]       dec_k,
   output logic [3:0]       dec_iv,
   input  logic [7:0]       dec_p,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_data,
   output logic             out_last,
   output logic             busy,
   output logic             done
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_EMIT  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t           state, state_nxt;
   logic [3:0]       key_r;
   logic [3:0]       iv_r;
   logic [7:0]       c_r;
   logic [LEN_W-1:0] remaining;
   logic [3:0]       wcnt;
   logic             in_fire;
   logic             wait_end;
   logic             msg_start;

   assign msg_start = (state == S_IDLE) && start && (len != '0);
   assign in_fire   = (state == S_FETCH) && in_valid;
   assign wait_end  = (state == S_WAIT) && (wcnt == 4'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      done      = 1'b0;
      busy      = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            if (msg_start) state_nxt = S_FETCH;
         end
         S_FETCH: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (wcnt == 4'd1) state_nxt = S_EMIT;
         end
         S_EMIT: begin
            out_valid = 1'b1;
            out_last  = (remaining == '0);
            if (out_ready) state_nxt = (remaining == '0) ? S_DONE : S_FETCH;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Message context: key fixed per message, IV chains from the previous ciphertext low nibble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_r     <= '0;
         iv_r      <= '0;
         remaining <= '0;
      end else if (msg_start) begin
         key_r     <= key;
         iv_r      <= iv;
         remaining <= len;
      end else if (wait_end) begin
         iv_r      <= c_r[3:0];
         remaining <= remaining - LEN_W'(1);
      end
   end

   // Decryptor operands are registered on accept so they cannot move outside WAIT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_r    <= '0;
         dec_k  <= '0;
         dec_iv <= '0;
         wcnt   <= '0;
      end else if (in_fire) begin
         c_r    <= in_data;
         dec_k  <= key_r;
         dec_iv <= iv_r;
         wcnt   <= 4'(DEC_WAIT);
      end else if (state == S_WAIT) begin
         wcnt   <= wcnt - 4'd1;
      end
   end

   assign dec_c = c_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data <= '0;
      end else if (wait_end) begin
         out_data <= dec_p;
      end
   end

endmodule

// File: tb/tb_cbc_stream_decrypt_ctrl.sv
// Randomized bench: a behavioural decryptor drives dec_p, expected bytes come from a per-message CBC model.
module tb_cbc_stream_decrypt_ctrl;

   localparam int LEN_W    = 8;
   localparam int DEC_WAIT = 3;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [3:0]       key;
   logic [3:0]       iv;
   logic [LEN_W-1:0] len;
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       in_data;
   logic [7:0]       dec_c;
   logic [3:0]       dec_k;
   logic [3:0]       dec_iv;
   logic [7:0]       dec_p;
   logic             out_valid;
   logic             out_ready;
   logic [7:0]       out_data;
   logic             out_last;
   logic             busy;
   logic             done;

   int n_checks;
   int n_fail;
   logic [7:0] msg_c [0:255];

   cbc_stream_decrypt_ctrl #(.LEN_W(LEN_W), .DEC_WAIT(DEC_WAIT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .key(key), .iv(iv), .len(len),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .dec_c(dec_c), .dec_k(dec_k), .dec_iv(dec_iv), .dec_p(dec_p),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .busy(busy), .done(done)
   );

   // Stand-in for the external block decryptor.
   function automatic logic [7:0] model_block_dec(input logic [7:0] c, input logic [3:0] k,
                                                  input logic [3:0] v);
      logic [7:0] t;
      t = {c[3:0], c[7:4]} ^ {k, k};
      return {t[7:4] ^ v, t[3:0] ^ (k + v)};
   endfunction

   assign dec_p = model_block_dec(dec_c, dec_k, dec_iv);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_out_last"},  32'(out_last),  32'd0);
      chk({tag, "_busy"},      32'(busy),      32'd0);
      chk({tag, "_done"},      32'(done),      32'd0);
      chk({tag, "_out_data"},  32'(out_data),  32'd0);
      chk({tag, "_dec_c"},     32'(dec_c),     32'd0);
      chk({tag, "_dec_k"},     32'(dec_k),     32'd0);
      chk({tag, "_dec_iv"},    32'(dec_iv),    32'd0);
   endtask

   // Runs one message from IDLE; called at a negedge. rst_idx aborts with async reset in WAIT of that byte.
   task automatic run_msg(input logic [3:0] k, input logic [3:0] v, input int n,
                          input int stall_idx, input int stall_len,
                          input int poke_idx, input int rst_idx);
      logic [3:0] civ;
      logic [7:0] p;
      logic       last;
      civ = v;
      chk("pre_busy", 32'(busy), 32'd0);
      start = 1'b1; key = k; iv = v; len = LEN_W'(n);
      @(negedge clk);
      start = 1'b0;
      chk("start_busy", 32'(busy), 32'd1);
      for (int i = 0; i < n; i++) begin
         p    = model_block_dec(msg_c[i], k, civ);
         last = (i == n - 1);
         key  = 4'($urandom); iv = 4'($urandom); len = LEN_W'($urandom);
         repeat ($urandom_range(0, 2)) begin
            chk("fetch_in_ready", 32'(in_ready), 32'd1);
            chk("fetch_out_valid", 32'(out_valid), 32'd0);
            @(negedge clk);
         end
         chk("fetch_in_ready", 32'(in_ready), 32'd1);
         in_valid = 1'b1; in_data = msg_c[i];
         @(negedge clk);
         in_valid = 1'b0; in_data = 8'($urandom);
         for (int w = 0; w < DEC_WAIT; w++) begin
            chk("wait_dec_c", 32'(dec_c), 32'(msg_c[i]));
            chk("wait_dec_k", 32'(dec_k), 32'(k));
            chk("wait_dec_iv", 32'(dec_iv), 32'(civ));
            chk("wait_out_valid", 32'(out_valid), 32'd0);
            chk("wait_in_ready", 32'(in_ready), 32'd0);
            if (i == poke_idx && w == 0) begin
               start = 1'b1; key = ~k; len = 8'd3;
            end
            if (i == rst_idx && w == DEC_WAIT - 1) begin
               #2 rst_n = 1'b0;
               #1 chk_all_zero("async_rst");
               @(negedge clk);
               rst_n = 1'b1;
               @(negedge clk);
               chk("post_rst_busy", 32'(busy), 32'd0);
               return;
            end
            @(negedge clk);
            start = 1'b0;
         end
         chk("emit_out_valid", 32'(out_valid), 32'd1);
         chk("emit_out_data", 32'(out_data), 32'(p));
         chk("emit_out_last", 32'(out_last), 32'(last));
         chk("emit_dec_c_hold", 32'(dec_c), 32'(msg_c[i]));
         chk("emit_dec_iv_hold", 32'(dec_iv), 32'(civ));
         if (i == stall_idx) begin
            for (int s = 0; s < stall_len; s++) begin
               out_ready = 1'b0;
               @(negedge clk);
               chk("stall_out_valid", 32'(out_valid), 32'd1);
               chk("stall_out_data", 32'(out_data), 32'(p));
               chk("stall_out_last", 32'(out_last), 32'(last));
               chk("stall_in_ready", 32'(in_ready), 32'd0);
            end
         end
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         civ = msg_c[i][3:0];
      end
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_busy", 32'(busy), 32'd1);
      chk("done_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("after_done", 32'(done), 32'd0);
      chk("after_busy", 32'(busy), 32'd0);
      chk("after_in_ready", 32'(in_ready), 32'd0);
   endtask

   task automatic load_t2();
      msg_c[0] = 8'd25; msg_c[1] = 8'd145; msg_c[2] = 8'd91;
      msg_c[3] = 8'd108; msg_c[4] = 8'd229;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int n;
      n_checks = 0; n_fail = 0;
      rst_n = 1'b0; start = 1'b0; key = '0; iv = '0; len = '0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      #1 chk_all_zero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      msg_c[0] = 8'd25;
      run_msg(4'd11, 4'd9, 1, -1, 0, -1, -1);

      load_t2();
      run_msg(4'd11, 4'd9, 5, -1, 0, -1, -1);
      run_msg(4'd11, 4'd9, 5, 1, 7, -1, -1);

      start = 1'b1; key = 4'd3; iv = 4'd5; len = '0;
      @(negedge clk);
      start = 1'b0;
      repeat (3) begin
         chk("len0_busy", 32'(busy), 32'd0);
         chk("len0_in_ready", 32'(in_ready), 32'd0);
         @(negedge clk);
      end
      run_msg(4'd11, 4'd9, 5, -1, 0, 2, -1);

      run_msg(4'd11, 4'd9, 5, -1, 0, -1, 1);
      for (int i = 0; i < 3; i++) msg_c[i] = 8'($urandom);
      run_msg(4'd7, 4'd4, 3, 0, 2, -1, -1);

      for (int m = 0; m < 20; m++) begin
         n = $urandom_range(1, 12);
         for (int i = 0; i < n; i++) msg_c[i] = 8'($urandom);
         run_msg(4'($urandom), 4'($urandom), n, $urandom_range(0, n - 1),
                 $urandom_range(0, 4), -1, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
